sudoku_cell_picker: RTL and testbench

//  Consumes 24-bit LFSR words and converts them into a sequence of unique Sudoku cell picks (row, col in 0..8).

---
 rtl/sudoku_pkg.sv | 34 +++
 rtl/sudoku_used_mask.sv | 27 ++
 rtl/sudoku_cell_picker.sv | 168 ++++++++++++++++
 tb/tb_sudoku_cell_picker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and index helpers for the Sudoku cell picker.
// Cells are numbered row-major: idx = row*GRID_N + col.
package sudoku_pkg;

    localparam int GRID_N = 9;
    localparam int CELLS  = GRID_N * GRID_N;

    typedef logic [6:0] cell_idx_t;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } cell_rc_t;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        PROBE,
        EMIT,
        DONE
    } picker_state_t;

    function automatic cell_idx_t rc_to_idx(input logic [3:0] row, input logic [3:0] col);
        return 7'({3'b000, row} * 7'(GRID_N) + {3'b000, col});
    endfunction

    function automatic cell_rc_t idx_to_rc(input cell_idx_t idx);
        cell_rc_t rc;
        rc.row = 4'(idx / 7'(GRID_N));
        rc.col = 4'(idx % 7'(GRID_N));
        return rc;
    endfunction

endpackage

// File: rtl/sudoku_used_mask.sv
// One bit per cell recording which cells were already issued this run.
// Indices outside the grid read as free and are never written.
module sudoku_used_mask
    import sudoku_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_clr,
    input  logic      i_set,
    input  cell_idx_t i_idx,
    output logic      o_used
);

    logic [CELLS-1:0] r_mask;
    logic             w_in_range;

    assign w_in_range = (i_idx < 7'(CELLS));
    assign o_used     = w_in_range ? r_mask[i_idx] : 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_mask <= '0;
        end else if (i_set && w_in_range) begin
            r_mask[i_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/sudoku_cell_picker.sv
// Turns LFSR words into a run of unique (row, col) Sudoku cell picks.
// Out-of-range or duplicate draws fall back to a linear probe so each pick finishes in bounded time.
module sudoku_cell_picker
    import sudoku_pkg::*;
#(
    parameter int MAX_REJECT = 8
) (
    input  logic        in_clka,
    input  logic        in_reset,
    input  logic        start,
    input  logic [6:0]  num_picks,
    input  logic [23:0] rand_in,
    input  logic        rand_valid,
    output logic        gen_rand_flag,
    output logic        pick_valid,
    input  logic        pick_ready,
    output logic [3:0]  pick_row,
    output logic [3:0]  pick_col,
    output logic        busy,
    output logic        done,
    output logic [7:0]  reject_cnt
);

    picker_state_t r_state, w_state_nxt;
    cell_idx_t     r_idx, w_idx_nxt, w_test_idx, w_draw_idx;
    logic [6:0]    r_n, r_count, w_n_clamped;
    logic [7:0]    r_consec, r_reject_cnt;
    cell_rc_t      r_pick, w_pick_rc;
    logic [3:0]    w_draw_r, w_draw_c;
    logic          w_draw_ok, w_used, w_accept;
    logic          w_start_run, w_mask_set, w_rej_inc, w_consec_inc, w_consec_clr;
    logic          w_idx_load, w_pick_load;
    logic          w_unused_rand;

    assign w_draw_r      = rand_in[3:0];
    assign w_draw_c      = rand_in[7:4];
    assign w_unused_rand = ^rand_in[23:8];
    assign w_draw_ok     = (w_draw_r < 4'(GRID_N)) && (w_draw_c < 4'(GRID_N));
    assign w_draw_idx    = rc_to_idx(w_draw_r, w_draw_c);
    assign w_test_idx    = (r_state == DRAW) ? w_draw_idx : r_idx;
    assign w_n_clamped   = (num_picks > 7'(CELLS)) ? 7'(CELLS) : num_picks;
    assign w_accept      = (r_state == EMIT) && pick_ready;

    sudoku_used_mask u_mask (
        .i_clk  (in_clka),
        .i_clr  (in_reset | w_start_run),
        .i_set  (w_mask_set),
        .i_idx  (w_test_idx),
        .o_used (w_used)
    );

    always_ff @(posedge in_clka) begin
        if (in_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_run  = 1'b0;
        w_mask_set   = 1'b0;
        w_rej_inc    = 1'b0;
        w_consec_inc = 1'b0;
        w_consec_clr = 1'b0;
        w_idx_load   = 1'b0;
        w_idx_nxt    = r_idx;
        w_pick_load  = 1'b0;
        w_pick_rc    = '{row: w_draw_r, col: w_draw_c};
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_start_run = 1'b1;
                    w_state_nxt = (w_n_clamped == 7'd0) ? DONE : DRAW;
                end
            end
            DRAW: begin
                if (rand_valid) begin
                    if (!w_draw_ok) begin
                        w_rej_inc = 1'b1;
                        // Too many misses in a row: derive a start cell and probe instead.
                        if (r_consec == 8'(MAX_REJECT - 1)) begin
                            w_consec_clr = 1'b1;
                            w_idx_load   = 1'b1;
                            w_idx_nxt    = rand_in[6:0] % 7'(CELLS);
                            w_state_nxt  = PROBE;
                        end else begin
                            w_consec_inc = 1'b1;
                        end
                    end else if (w_used) begin
                        w_rej_inc    = 1'b1;
                        w_consec_clr = 1'b1;
                        w_idx_load   = 1'b1;
                        w_idx_nxt    = w_draw_idx;
                        w_state_nxt  = PROBE;
                    end else begin
                        w_consec_clr = 1'b1;
                        w_mask_set   = 1'b1;
                        w_pick_load  = 1'b1;
                        w_state_nxt  = EMIT;
                    end
                end
            end
            PROBE: begin
                if (!w_used) begin
                    w_mask_set  = 1'b1;
                    w_pick_load = 1'b1;
                    w_pick_rc   = idx_to_rc(r_idx);
                    w_state_nxt = EMIT;
                end else begin
                    w_idx_load = 1'b1;
                    w_idx_nxt  = (r_idx == 7'(CELLS - 1)) ? 7'd0 : r_idx + 7'd1;
                end
            end
            EMIT: begin
                if (pick_ready) begin
                    w_state_nxt = (r_count + 7'd1 == r_n) ? DONE : DRAW;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_clka) begin
        if (in_reset) begin
            r_n          <= '0;
            r_count      <= '0;
            r_consec     <= '0;
            r_reject_cnt <= '0;
            r_idx        <= '0;
            r_pick       <= '0;
        end else begin
            if (w_start_run) begin
                r_n          <= w_n_clamped;
                r_count      <= '0;
                r_consec     <= '0;
                r_reject_cnt <= '0;
            end
            if (w_rej_inc && (r_reject_cnt != 8'hFF)) begin
                r_reject_cnt <= r_reject_cnt + 8'd1;
            end
            if (w_consec_clr) begin
                r_consec <= '0;
            end else if (w_consec_inc) begin
                r_consec <= r_consec + 8'd1;
            end
            if (w_idx_load) begin
                r_idx <= w_idx_nxt;
            end
            if (w_pick_load) begin
                r_pick <= w_pick_rc;
            end
            if (w_accept) begin
                r_count <= r_count + 7'd1;
            end
        end
    end

    assign gen_rand_flag = (r_state == DRAW);
    assign pick_valid    = (r_state == EMIT);
    assign busy          = (r_state == DRAW) || (r_state == PROBE) || (r_state == EMIT);
    assign done          = (r_state == DONE);
    assign pick_row      = r_pick.row;
    assign pick_col      = r_pick.col;
    assign reject_cnt    = r_reject_cnt;

endmodule

// File: tb/tb_sudoku_cell_picker.sv
// Directed bench for sudoku_cell_picker: table of single-run vectors plus hand-written
// sequences for latency, corner starts, mid-run reset and a full 81-cell run with backpressure.
module tb_sudoku_cell_picker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  num_picks;
    logic [23:0] rand_in;
    logic        rand_valid;
    logic        gen_rand_flag;
    logic        pick_valid;
    logic        pick_ready;
    logic [3:0]  pick_row;
    logic [3:0]  pick_col;
    logic        busy;
    logic        done;
    logic [7:0]  reject_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    sudoku_cell_picker dut (
        .in_clka       (clk),
        .in_reset      (rst),
        .start         (start),
        .num_picks     (num_picks),
        .rand_in       (rand_in),
        .rand_valid    (rand_valid),
        .gen_rand_flag (gen_rand_flag),
        .pick_valid    (pick_valid),
        .pick_ready    (pick_ready),
        .pick_row      (pick_row),
        .pick_col      (pick_col),
        .busy          (busy),
        .done          (done),
        .reject_cnt    (reject_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [6:0]       num;
        int               nw;
        logic [0:7][23:0] w;
        logic [23:0]      fill;
        int               ne;
        logic [0:1][7:0]  rc;
        logic [7:0]       rej;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [6:0] n);
        start     = 1'b1;
        num_picks = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Feeds the vector's words on each DRAW request and accepts every pick immediately.
    task automatic run_vec(input vec_t v);
        int k   = 0;
        int np  = 0;
        int cyc = 0;
        int exp_np;
        exp_np = (v.num > 7'd81) ? 81 : int'(v.num);
        @(negedge clk);
        pulse_start(v.num);
        while (!done && cyc < 20000) begin
            rand_valid = 1'b0;
            pick_ready = 1'b0;
            if (gen_rand_flag) begin
                rand_in    = (k < v.nw) ? v.w[k] : v.fill;
                rand_valid = 1'b1;
                k++;
            end
            if (pick_valid) begin
                if (np < v.ne) begin
                    check({v.name, " row"}, pick_row, v.rc[np][7:4]);
                    check({v.name, " col"}, pick_col, v.rc[np][3:0]);
                end
                np++;
                pick_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        rand_valid = 1'b0;
        pick_ready = 1'b0;
        check({v.name, " done"}, done, 1);
        check({v.name, " busy"}, busy, 0);
        check({v.name, " picks"}, np, exp_np);
        check({v.name, " reject_cnt"}, reject_cnt, v.rej);
    endtask

    initial begin
        vecs[0] = '{"basic", 7'd1, 1, {24'h000032, {7{24'h0}}}, 24'h0, 1, 16'h2300, 8'd0};
        vecs[1] = '{"out_of_range", 7'd1, 2, {24'h0000F3, 24'h000032, {6{24'h0}}}, 24'h0, 1, 16'h2300, 8'd1};
        vecs[2] = '{"duplicate", 7'd2, 2, {24'h000032, 24'h000032, {6{24'h0}}}, 24'h0, 2, 16'h2324, 8'd1};
        vecs[3] = '{"probe_wrap", 7'd2, 2, {24'h000088, 24'h000088, {6{24'h0}}}, 24'h0, 2, 16'h8800, 8'd1};
        vecs[4] = '{"forced_probe", 7'd1, 8, {8{24'h0000FF}}, 24'h0, 1, 16'h5100, 8'd8};
        vecs[5] = '{"seven_rejects", 7'd1, 8, {{7{24'h0000FF}}, 24'h000000}, 24'h0, 1, 16'h0000, 8'd7};
        vecs[6] = '{"nine_boundary", 7'd1, 3, {24'h000009, 24'h000090, 24'h000088, {5{24'h0}}}, 24'h0, 1, 16'h8800, 8'd2};
        vecs[7] = '{"reject_saturate", 7'd40, 0, {8{24'h0}}, 24'h0000FF, 2, 16'h5152, 8'd255};
        vecs[8] = '{"upper_bits_ignored", 7'd2, 2, {24'hFFFF10, 24'hABC021, {6{24'h0}}}, 24'h0, 2, 16'h0112, 8'd0};

        rst        = 1'b1;
        start      = 1'b0;
        num_picks  = '0;
        rand_in    = '0;
        rand_valid = 1'b0;
        pick_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset pick_valid", pick_valid, 0);
        check("reset gen_rand_flag", gen_rand_flag, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset reject_cnt", reject_cnt, 0);
        check("reset pick_rc", {pick_row, pick_col}, 0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Draw-to-pick latency is exactly one cycle.
        @(negedge clk);
        pulse_start(7'd1);
        check("lat gen_rand_flag", gen_rand_flag, 1);
        rand_in    = 24'h000032;
        rand_valid = 1'b1;
        @(negedge clk);
        rand_valid = 1'b0;
        check("lat pick_valid", pick_valid, 1);
        check("lat pick_rc", {pick_row, pick_col}, 8'h23);
        check("lat gen_rand_flag off", gen_rand_flag, 0);
        pick_ready = 1'b1;
        @(negedge clk);
        pick_ready = 1'b0;
        check("lat done", done, 1);
        check("lat pick_valid off", pick_valid, 0);

        // Zero picks: straight to DONE.
        pulse_start(7'd0);
        check("zero done", done, 1);
        check("zero busy", busy, 0);
        check("zero pick_valid", pick_valid, 0);
        check("zero gen_rand_flag", gen_rand_flag, 0);

        // start while busy is ignored.
        pulse_start(7'd2);
        pulse_start(7'd0);
        check("busy_start busy", busy, 1);
        check("busy_start done", done, 0);
        rand_in    = 24'h000032;
        rand_valid = 1'b1;
        @(negedge clk);
        rand_valid = 1'b0;
        pick_ready = 1'b1;
        @(negedge clk);
        pick_ready = 1'b0;
        check("busy_start still running", busy, 1);
        rand_in    = 24'h000045;
        rand_valid = 1'b1;
        @(negedge clk);
        rand_valid = 1'b0;
        check("busy_start pick2", {pick_row, pick_col}, 8'h54);
        pick_ready = 1'b1;
        @(negedge clk);
        pick_ready = 1'b0;
        check("busy_start done end", done, 1);

        // Reset during EMIT aborts the run.
        pulse_start(7'd2);
        rand_in    = 24'h000032;
        rand_valid = 1'b1;
        @(negedge clk);
        rand_valid = 1'b0;
        check("midrst in EMIT", pick_valid, 1);
        rst        = 1'b1;
        pick_ready = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        pick_ready = 1'b0;
        check("midrst pick_valid", pick_valid, 0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst reject_cnt", reject_cnt, 0);
        run_vec(vecs[0]);

        // Full grid with random words, random rand_valid and random backpressure.
        begin
            bit         seen[81];
            logic       held = 1'b0;
            logic [7:0] hold_rc = '0;
            int np = 0, dup = 0, unstable = 0, bad = 0, cyc = 0;
            pulse_start(7'd100);
            while (!done && cyc < 60000) begin
                rand_in    = 24'($urandom);
                rand_valid = 1'($urandom_range(0, 1));
                pick_ready = 1'b0;
                if (pick_valid) begin
                    if (held && ({pick_row, pick_col} !== hold_rc)) unstable++;
                    pick_ready = 1'($urandom_range(0, 1));
                    if (pick_ready) begin
                        held = 1'b0;
                        if (pick_row > 4'd8 || pick_col > 4'd8) begin
                            bad++;
                        end else if (seen[int'(pick_row) * 9 + int'(pick_col)]) begin
                            dup++;
                        end else begin
                            seen[int'(pick_row) * 9 + int'(pick_col)] = 1'b1;
                        end
                        np++;
                    end else begin
                        held    = 1'b1;
                        hold_rc = {pick_row, pick_col};
                    end
                end
                @(negedge clk);
                cyc++;
            end
            rand_valid = 1'b0;
            pick_ready = 1'b0;
            check("full done", done, 1);
            check("full picks", np, 81);
            check("full duplicates", dup, 0);
            check("full out_of_grid", bad, 0);
            check("full stall_stability", unstable, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
